// File: rtl/controle_valvulas.sv
// Multi-channel valve controller: manual/auto arbitration, latched auto requests,
// minimum dwell between output changes and auto-mode open timeout with fault lockout.
//
// state   | meaning
// FECHADA | valve closed, may open once dwell has elapsed
// ABERTA  | valve open, counting consecutive open cycles
// TRAVADA | auto timeout fault, valve forced closed until manual or fecha_auto
module controle_valvulas #(
   parameter int N_CH      = 4,
   parameter int MIN_DWELL = 8,
   parameter int MAX_OPEN  = 1000
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [N_CH-1:0]              manual,
   input  logic [N_CH-1:0]              abre_manual,
   input  logic [N_CH-1:0]              abre_auto,
   input  logic [N_CH-1:0]              fecha_auto,
   output logic [N_CH-1:0]              abre_valvula,
   output logic [N_CH-1:0]              falha,
   output logic                         alguma_falha,
   output logic [$clog2(N_CH+1)-1:0]    qtd_abertas
);

   localparam int MAX_VAL = (MIN_DWELL > MAX_OPEN) ? MIN_DWELL : MAX_OPEN;
   localparam int CW      = $clog2(MAX_VAL + 2);
   localparam int QW      = $clog2(N_CH + 1);

   localparam logic [CW-1:0] DWELL_C    = CW'(MIN_DWELL);
   localparam logic [CW-1:0] OPEN_C     = CW'(MAX_OPEN);
   localparam logic          TIMEOUT_ON = (MAX_OPEN != 0);

   typedef enum logic [1:0] {
      FECHADA = 2'd0,
      ABERTA  = 2'd1,
      TRAVADA = 2'd2
   } estado_t;

   for (genvar i = 0; i < N_CH; i++) begin : g_canal
      estado_t       estado;
      estado_t       estado_prox;
      logic          desejo;
      logic          desejo_prox;
      logic [CW-1:0] contador;
      logic          pronto;
      logic          abre_q;
      logic          falha_q;

      assign pronto = (contador >= DWELL_C);

      always_comb begin
         desejo_prox = desejo;
         if (estado == TRAVADA)
            desejo_prox = 1'b0;
         else if (manual[i])
            desejo_prox = abre_manual[i];
         else if (abre_auto[i])
            desejo_prox = 1'b1;
         else if (fecha_auto[i])
            desejo_prox = 1'b0;
      end

      // Timeout has priority over a close request that lands on the same edge.
      always_comb begin
         estado_prox = estado;
         case (estado)
            FECHADA: begin
               if (desejo_prox && pronto)
                  estado_prox = ABERTA;
            end
            ABERTA: begin
               if (!manual[i] && TIMEOUT_ON && (contador >= OPEN_C))
                  estado_prox = TRAVADA;
               else if (!desejo_prox && pronto)
                  estado_prox = FECHADA;
            end
            TRAVADA: begin
               if (manual[i] || fecha_auto[i])
                  estado_prox = FECHADA;
            end
            default: estado_prox = FECHADA;
         endcase
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            estado   <= FECHADA;
            desejo   <= 1'b0;
            contador <= '1;
            abre_q   <= 1'b0;
            falha_q  <= 1'b0;
         end else begin
            estado <= estado_prox;
            desejo <= desejo_prox;
            if (estado_prox != estado)
               contador <= CW'(1);
            else if (contador != '1)
               contador <= contador + CW'(1);
            abre_q  <= (estado_prox == ABERTA);
            falha_q <= (estado_prox == TRAVADA);
         end
      end

      assign abre_valvula[i] = abre_q;
      assign falha[i]        = falha_q;
   end

   always_comb begin
      qtd_abertas = '0;
      for (int i = 0; i < N_CH; i++)
         qtd_abertas = qtd_abertas + QW'(abre_valvula[i]);
   end

   assign alguma_falha = |falha;

endmodule

// File: tb/tb_controle_valvulas.sv
// Bench for controle_valvulas: vector table plus hand-written multi-cycle sequences,
// expectations queued when driven and compared one edge later.
module tb_controle_valvulas;

   logic       clock;
   logic       reset;
   logic [3:0] manual;
   logic [3:0] abre_manual;
   logic [3:0] abre_auto;
   logic [3:0] fecha_auto;
   logic [3:0] abre_valvula;
   logic [3:0] falha;
   logic       alguma_falha;
   logic [2:0] qtd_abertas;

   controle_valvulas #(
      .N_CH      (4),
      .MIN_DWELL (8),
      .MAX_OPEN  (20)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .manual       (manual),
      .abre_manual  (abre_manual),
      .abre_auto    (abre_auto),
      .fecha_auto   (fecha_auto),
      .abre_valvula (abre_valvula),
      .falha        (falha),
      .alguma_falha (alguma_falha),
      .qtd_abertas  (qtd_abertas)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       rst;
      logic [3:0] man;
      logic [3:0] am;
      logic [3:0] aa;
      logic [3:0] fa;
      logic [3:0] ea;
      logic [3:0] ef;
   } vetor_t;

   typedef struct {
      logic [3:0] ea;
      logic [3:0] ef;
   } esperado_t;

   esperado_t sb[$];
   string     nomes[$];
   int        erros  = 0;
   int        checks = 0;
   vetor_t    tab[10];

   task automatic conferir(input string nome, input string campo, input int got, input int want);
      checks++;
      if (got != want) begin
         erros++;
         $display("FAIL %s %s: got %0d want %0d (t=%0t)", nome, campo, got, want, $time);
      end
   endtask

   task automatic passo(input logic rst, input logic [3:0] man, input logic [3:0] am,
                        input logic [3:0] aa, input logic [3:0] fa,
                        input logic [3:0] ea, input logic [3:0] ef, input string nome);
      esperado_t e;
      string     n;
      reset       = rst;
      manual      = man;
      abre_manual = am;
      abre_auto   = aa;
      fecha_auto  = fa;
      sb.push_back('{ea, ef});
      nomes.push_back(nome);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      n = nomes.pop_front();
      conferir(n, "abre_valvula", int'(abre_valvula), int'(e.ea));
      conferir(n, "falha",        int'(falha),        int'(e.ef));
      conferir(n, "alguma_falha", int'(alguma_falha), int'(|e.ef));
      conferir(n, "qtd_abertas",  int'(qtd_abertas),  $countones(e.ea));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      manual      = '0;
      abre_manual = '0;
      abre_auto   = '0;
      fecha_auto  = '0;

      //           rst   man      am       aa       fa       ea       ef
      tab[0] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tab[1] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tab[2] = '{1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
      tab[3] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
      tab[4] = '{1'b0, 4'b0000, 4'b0000, 4'b0110, 4'b0110, 4'b0111, 4'b0000};
      tab[5] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b0000};
      tab[6] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tab[7] = '{1'b0, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000};
      tab[8] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000};
      tab[9] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

      for (int i = 0; i < 10; i++)
         passo(tab[i].rst, tab[i].man, tab[i].am, tab[i].aa, tab[i].fa,
               tab[i].ea, tab[i].ef, $sformatf("tabela[%0d]", i));

      // dwell: open ch1, early close request, output must stay high exactly 8 cycles
      passo(1, 0, 0, 0, 0, 4'b0000, 0, "t2_reset");
      passo(0, 0, 0, 4'b0010, 0, 4'b0010, 0, "t2_abre");
      passo(0, 0, 0, 0, 0, 4'b0010, 0, "t2_segura");
      passo(0, 0, 0, 0, 4'b0010, 4'b0010, 0, "t2_fecha_cedo");
      for (int k = 0; k < 5; k++)
         passo(0, 0, 0, 0, 0, 4'b0010, 0, "t2_dwell");
      passo(0, 0, 0, 0, 0, 4'b0000, 0, "t2_fecha_8");
      passo(0, 0, 0, 0, 0, 4'b0000, 0, "t2_fechada");

      // timeout: abre_auto[2] held, lock after 20, clear, reopen after dwell
      passo(1, 0, 0, 0, 0, 4'b0000, 0, "t3_reset");
      for (int k = 0; k < 20; k++)
         passo(0, 0, 0, 4'b0100, 0, 4'b0100, 0, "t3_aberta");
      passo(0, 0, 0, 4'b0100, 0, 4'b0000, 4'b0100, "t3_trava");
      for (int k = 0; k < 5; k++)
         passo(0, 0, 0, 4'b0100, 0, 4'b0000, 4'b0100, "t3_sem_reabrir");
      passo(0, 0, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, "t3_limpa");
      for (int k = 0; k < 7; k++)
         passo(0, 0, 0, 4'b0100, 0, 4'b0000, 0, "t3_dwell_reabre");
      passo(0, 0, 0, 4'b0100, 0, 4'b0100, 0, "t3_reabre");
      for (int k = 0; k < 19; k++)
         passo(0, 0, 0, 4'b0100, 0, 4'b0100, 0, "t3_aberta2");
      passo(0, 0, 0, 4'b0100, 0, 4'b0000, 4'b0100, "t3_trava2");

      // reset while locked and while open
      passo(1, 0, 0, 4'b0100, 0, 4'b0000, 0, "t6_reset_travada");
      passo(0, 0, 0, 4'b0100, 0, 4'b0100, 0, "t6_abre_pos_reset");
      passo(1, 0, 0, 0, 0, 4'b0000, 0, "t6_reset_aberta");

      // manual mode: no timeout, fecha_auto ignored, dwell still applies
      for (int k = 0; k < 30; k++)
         passo(0, 4'b1000, 4'b1000, 0, 0, 4'b1000, 0, "t4_manual");
      for (int k = 0; k < 20; k++)
         passo(0, 4'b1000, 4'b1000, 0, 4'b1000, 4'b1000, 0, "t4_manual_fecha_auto");
      passo(0, 0, 0, 0, 0, 4'b0000, 4'b1000, "t4_volta_auto_trava");
      passo(0, 0, 0, 0, 4'b1000, 4'b0000, 0, "t4_limpa");
      for (int k = 0; k < 7; k++)
         passo(0, 4'b1000, 4'b1000, 0, 0, 4'b0000, 0, "t4_manual_dwell");
      passo(0, 4'b1000, 4'b1000, 0, 0, 4'b1000, 0, "t4_manual_abre");
      for (int k = 0; k < 7; k++)
         passo(0, 4'b1000, 4'b0000, 0, 0, 4'b1000, 0, "t4_manual_fecha_dwell");
      passo(0, 4'b1000, 4'b0000, 0, 0, 4'b0000, 0, "t4_manual_fecha");
      passo(0, 0, 0, 0, 0, 4'b0000, 0, "t4_auto_mantem");

      $display("Result: errors=%0d of %0d checks", erros, checks);
      $finish;
   end

endmodule
